// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with operand forwarding select, load-use bubble insertion,
// EX flush (remembered across a MEM stall) and PC / IF-ID hold generation.
// Optional build macro ID_EX_PERF_CNT_EN adds bubble/flush event counters.
module id_ex_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_id,
    input  logic [XLEN-1:0]    pc_id,
    input  logic [XLEN-1:0]    imm_id,
    input  logic [XLEN-1:0]    rdata1_id,
    input  logic [XLEN-1:0]    rdata2_id,
    input  logic [4:0]         rs1_id,
    input  logic [4:0]         rs2_id,
    input  logic [4:0]         rd_id,
    input  logic               rf_we_id,
    input  logic               mem_we_id,
    input  logic               is_load_id,
    input  logic               is_branch_id,
    input  logic [ALUOP_W-1:0] alu_op_id,
    input  logic [1:0]         wb_sel_id,
    input  logic [XLEN-1:0]    rdata1_f,
    input  logic [XLEN-1:0]    rdata2_f,
    input  logic               rd1_sel,
    input  logic               rd2_sel,
    input  logic               load_stop,
    input  logic               flush_ex,
    input  logic               mem_stall,
    output logic               valid_ex,
    output logic [XLEN-1:0]    pc_ex,
    output logic [XLEN-1:0]    imm_ex,
    output logic [XLEN-1:0]    op1_ex,
    output logic [XLEN-1:0]    op2_ex,
    output logic [4:0]         rs1_ex,
    output logic [4:0]         rs2_ex,
    output logic [4:0]         rd_ex,
    output logic               rf_we_ex,
    output logic               mem_we_ex,
    output logic               is_load_ex,
    output logic               is_branch_ex,
    output logic [ALUOP_W-1:0] alu_op_ex,
    output logic [1:0]         wb_sel_ex,
    output logic               pc_hold,
    output logic               if_id_hold
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]        bubble_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               rf_we;
        logic               mem_we;
        logic               is_load;
        logic               is_branch;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         wb_sel;
    } ex_t;

    typedef enum logic {IDLE, FLUSH_PEND} state_t;

    state_t r_state, w_state_next;
    ex_t    r_ex, w_ex_next;
    logic   w_flush;
    logic   w_bubble_evt;
    logic   w_flush_evt;

    assign w_flush = flush_ex | (r_state == FLUSH_PEND);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_ex_next    = r_ex;
        w_bubble_evt = 1'b0;
        w_flush_evt  = 1'b0;
        if (mem_stall) begin
            if (flush_ex) w_state_next = FLUSH_PEND;
        end else if (w_flush) begin
            w_ex_next    = '0;
            w_state_next = IDLE;
            w_flush_evt  = 1'b1;
        end else if (load_stop) begin
            w_ex_next    = '0;
            w_bubble_evt = 1'b1;
        end else begin
            w_ex_next.valid     = valid_id;
            w_ex_next.pc        = pc_id;
            w_ex_next.imm       = imm_id;
            w_ex_next.op1       = rd1_sel ? rdata1_f : rdata1_id;
            w_ex_next.op2       = rd2_sel ? rdata2_f : rdata2_id;
            w_ex_next.rs1       = rs1_id;
            w_ex_next.rs2       = rs2_id;
            w_ex_next.rd        = rd_id;
            w_ex_next.rf_we     = rf_we_id & valid_id;
            w_ex_next.mem_we    = mem_we_id & valid_id;
            w_ex_next.is_load   = is_load_id & valid_id;
            w_ex_next.is_branch = is_branch_id & valid_id;
            w_ex_next.alu_op    = alu_op_id;
            w_ex_next.wb_sel    = wb_sel_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ex    <= '0;
        end else begin
            r_state <= w_state_next;
            r_ex    <= w_ex_next;
        end
    end

    // A pending or current flush wins over a load stall so the PC can redirect.
    assign pc_hold    = mem_stall | (load_stop & ~w_flush);
    assign if_id_hold = pc_hold;

    assign valid_ex     = r_ex.valid;
    assign pc_ex        = r_ex.pc;
    assign imm_ex       = r_ex.imm;
    assign op1_ex       = r_ex.op1;
    assign op2_ex       = r_ex.op2;
    assign rs1_ex       = r_ex.rs1;
    assign rs2_ex       = r_ex.rs2;
    assign rd_ex        = r_ex.rd;
    assign rf_we_ex     = r_ex.rf_we;
    assign mem_we_ex    = r_ex.mem_we;
    assign is_load_ex   = r_ex.is_load;
    assign is_branch_ex = r_ex.is_branch;
    assign alu_op_ex    = r_ex.alu_op;
    assign wb_sel_ex    = r_ex.wb_sel;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_bubble_evt) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_flush_evt)  r_flush_cnt  <= r_flush_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_bubble_evt | w_flush_evt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg: reset, forwarding select, valid gating,
// load-use bubble, flush priority, flush remembered across MEM stall, mid-run reset.
module tb_id_ex_pipe_reg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_id;
    logic [XLEN-1:0]    pc_id, imm_id, rdata1_id, rdata2_id, rdata1_f, rdata2_f;
    logic [4:0]         rs1_id, rs2_id, rd_id;
    logic               rf_we_id, mem_we_id, is_load_id, is_branch_id;
    logic [ALUOP_W-1:0] alu_op_id;
    logic [1:0]         wb_sel_id;
    logic               rd1_sel, rd2_sel, load_stop, flush_ex, mem_stall;
    logic               valid_ex;
    logic [XLEN-1:0]    pc_ex, imm_ex, op1_ex, op2_ex;
    logic [4:0]         rs1_ex, rs2_ex, rd_ex;
    logic               rf_we_ex, mem_we_ex, is_load_ex, is_branch_ex;
    logic [ALUOP_W-1:0] alu_op_ex;
    logic [1:0]         wb_sel_ex;
    logic               pc_hold, if_id_hold;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]        bubble_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id), .imm_id(imm_id),
        .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .rf_we_id(rf_we_id), .mem_we_id(mem_we_id), .is_load_id(is_load_id),
        .is_branch_id(is_branch_id), .alu_op_id(alu_op_id), .wb_sel_id(wb_sel_id),
        .rdata1_f(rdata1_f), .rdata2_f(rdata2_f), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
        .load_stop(load_stop), .flush_ex(flush_ex), .mem_stall(mem_stall),
        .valid_ex(valid_ex), .pc_ex(pc_ex), .imm_ex(imm_ex), .op1_ex(op1_ex), .op2_ex(op2_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rf_we_ex(rf_we_ex),
        .mem_we_ex(mem_we_ex), .is_load_ex(is_load_ex), .is_branch_ex(is_branch_ex),
        .alu_op_ex(alu_op_ex), .wb_sel_ex(wb_sel_ex), .pc_hold(pc_hold), .if_id_hold(if_id_hold)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        valid_id = 1'($urandom); pc_id = $urandom; imm_id = $urandom;
        rdata1_id = $urandom; rdata2_id = $urandom; rdata1_f = $urandom; rdata2_f = $urandom;
        rs1_id = 5'($urandom); rs2_id = 5'($urandom); rd_id = 5'($urandom);
        rf_we_id = 1'($urandom); mem_we_id = 1'($urandom); is_load_id = 1'($urandom);
        is_branch_id = 1'($urandom); alu_op_id = 4'($urandom); wb_sel_id = 2'($urandom);
        rd1_sel = 1'($urandom); rd2_sel = 1'($urandom); load_stop = 1'($urandom);
        flush_ex = 1'($urandom); mem_stall = 1'($urandom);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, 64'(valid_ex), 64'd0);
        check({tag, "_ctrl"}, 64'({rf_we_ex, mem_we_ex, is_load_ex, is_branch_ex}), 64'd0);
        check({tag, "_rd"}, 64'(rd_ex), 64'd0);
        check({tag, "_op1"}, 64'(op1_ex), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        load_stop = 1'b0; mem_stall = 1'b0;
        #1;
        check("rst_any_ex", 64'(|{valid_ex, pc_ex, imm_ex, op1_ex, op2_ex, rs1_ex, rs2_ex, rd_ex,
                                  rf_we_ex, mem_we_ex, is_load_ex, is_branch_ex, alu_op_ex,
                                  wb_sel_ex}), 64'd0);
        check("rst_pc_hold", 64'({pc_hold, if_id_hold}), 64'd0);

        // Baseline instruction with operand 1 forwarded.
        rst_n = 1'b1; flush_ex = 1'b0;
        valid_id = 1'b1; pc_id = 32'h100; imm_id = 32'h4;
        rdata1_id = 32'h11; rdata1_f = 32'hAA; rd1_sel = 1'b1;
        rdata2_id = 32'h22; rdata2_f = 32'hBB; rd2_sel = 1'b0;
        rs1_id = 5'd1; rs2_id = 5'd2; rd_id = 5'd3;
        rf_we_id = 1'b1; mem_we_id = 1'b0; is_load_id = 1'b0; is_branch_id = 1'b0;
        alu_op_id = 4'd5; wb_sel_id = 2'd2;
        step();
        check("fwd_op1", 64'(op1_ex), 64'hAA);
        check("fwd_op2", 64'(op2_ex), 64'h22);
        check("cap_pc", 64'(pc_ex), 64'h100);
        check("cap_misc", 64'({valid_ex, rs1_ex, rs2_ex, rd_ex, rf_we_ex, alu_op_ex, wb_sel_ex}),
              64'({1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 4'd5, 2'd2}));

        rd1_sel = 1'b0; rd2_sel = 1'b1;
        step();
        check("fwd_swap_op1", 64'(op1_ex), 64'h11);
        check("fwd_swap_op2", 64'(op2_ex), 64'hBB);

        // Invalid ID instruction: control bits gated, other fields still captured.
        valid_id = 1'b0; mem_we_id = 1'b1; is_load_id = 1'b1; is_branch_id = 1'b1;
        rd_id = 5'd4; pc_id = 32'h104;
        step();
        check("inv_valid", 64'(valid_ex), 64'd0);
        check("inv_ctrl", 64'({rf_we_ex, mem_we_ex, is_load_ex, is_branch_ex}), 64'd0);
        check("inv_rd", 64'(rd_ex), 64'd4);
        check("inv_pc", 64'(pc_ex), 64'h104);

        // Load-use: one bubble, then the held instruction is captured.
        valid_id = 1'b1; mem_we_id = 1'b0; is_load_id = 1'b0; is_branch_id = 1'b0;
        rd_id = 5'd5; rf_we_id = 1'b1; pc_id = 32'h108; load_stop = 1'b1;
        #1;
        check("lu_holds", 64'({pc_hold, if_id_hold}), 64'b11);
        step();
        check_bubble("lu_bubble");
        load_stop = 1'b0;
        #1;
        check("lu_release", 64'(pc_hold), 64'd0);
        step();
        check("lu_recap", 64'({valid_ex, rf_we_ex, rd_ex}), 64'({1'b1, 1'b1, 5'd5}));

        // Flush and load stall together: holds released, bubble loaded.
        flush_ex = 1'b1; load_stop = 1'b1;
        #1;
        check("fl_ls_holds", 64'({pc_hold, if_id_hold}), 64'd0);
        step();
        check_bubble("fl_ls_bubble");

        flush_ex = 1'b0; load_stop = 1'b0; rd_id = 5'd7; pc_id = 32'h200;
        step();
        check("pre_stall_rd", 64'(rd_ex), 64'd7);

        // Flush arriving under a MEM stall is remembered until the stall clears.
        mem_stall = 1'b1; flush_ex = 1'b1; rd_id = 5'd9; pc_id = 32'h300;
        #1;
        check("stall_hold", 64'(pc_hold), 64'd1);
        step();
        check("stall1", 64'({valid_ex, rd_ex, pc_ex}), 64'({1'b1, 5'd7, 32'h200}));
        flush_ex = 1'b0;
        step();
        check("stall2", 64'({valid_ex, rd_ex, pc_ex}), 64'({1'b1, 5'd7, 32'h200}));
        step();
        check("stall3", 64'({valid_ex, rd_ex, pc_ex}), 64'({1'b1, 5'd7, 32'h200}));
        mem_stall = 1'b0; load_stop = 1'b1;
        #1;
        check("pend_overrides_ls", 64'(pc_hold), 64'd0);
        step();
        check_bubble("pend_bubble");
        #1;
        check("pend_cleared", 64'(pc_hold), 64'd1);
        step();
        check_bubble("lu2_bubble");
        step();
        check_bubble("lu3_bubble");
        load_stop = 1'b0;
        step();
        check("post_pend_cap", 64'({valid_ex, rd_ex, pc_ex}), 64'({1'b1, 5'd9, 32'h300}));
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'd3);
        check("flush_cnt", 64'(flush_cnt), 64'd2);
`endif

        // Reset mid-run with a flush pending empties the pipe and drops the flush.
        mem_stall = 1'b1; flush_ex = 1'b1;
        step();
        rst_n = 1'b0; mem_stall = 1'b0; flush_ex = 1'b0;
        step();
        check("mid_rst_rd", 64'({valid_ex, rd_ex, pc_ex}), 64'd0);
        rst_n = 1'b1; load_stop = 1'b1;
        #1;
        check("mid_rst_pend_clr", 64'(pc_hold), 64'd1);
        load_stop = 1'b0;
        step();
        check("after_rst_cap", 64'({valid_ex, rd_ex}), 64'({1'b1, 5'd9}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register of the 5-stage pipeline: captures decoded ID-stage fields each cycle, replaces register-file operands with forwarded values when the forwarding unit selects them, and inserts a bubble on a load-use hazard. It sits directly downstream of the forwarding unit, consuming `rdata*_f`, `rd*_sel` and `load_stop`, and feeds the EX stage. It also handles branch flush from EX and a back-pressure hold from MEM, and generates the hold signals for the PC and IF/ID registers.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `ALUOP_W`, 4, ALU opcode width

Ports:
- `clk`  in  1  clock, all state updates on the rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `valid_id`  in  1  ID holds a real instruction
- `pc_id`, `imm_id`  in  XLEN  PC and immediate of the ID instruction
- `rdata1_id`, `rdata2_id`  in  XLEN  register-file read data
- `rs1_id`, `rs2_id`, `rd_id`  in  5  register indices
- `rf_we_id`, `mem_we_id`, `is_load_id`, `is_branch_id`  in  1  control bits
- `alu_op_id`  in  ALUOP_W  ALU operation
- `wb_sel_id`  in  2  writeback source select
- `rdata1_f`, `rdata2_f`  in  XLEN  forwarded operands
- `rd1_sel`, `rd2_sel`  in  1  1 = use forwarded operand
- `load_stop`  in  1  load-use hazard, insert a bubble
- `flush_ex`  in  1  taken branch/jump resolved in EX
- `mem_stall`  in  1  MEM not ready, hold ID/EX
- `*_ex` outputs  out  same widths as the `*_id` inputs  registered copies (`valid_ex`, `pc_ex`, `imm_ex`, `op1_ex`, `op2_ex`, `rs1_ex`, `rs2_ex`, `rd_ex`, `rf_we_ex`, `mem_we_ex`, `is_load_ex`, `is_branch_ex`, `alu_op_ex`, `wb_sel_ex`)
- `pc_hold`  out  1  freeze PC
- `if_id_hold`  out  1  freeze IF/ID

## Operation
- Operand select: `op1_next = rd1_sel ? rdata1_f : rdata1_id`. `op2_next` is formed the same way from `rd2_sel`.
- Update priority per rising edge, highest first:
  1. `!rst_n`: all outputs are 0; `flush_pending` is 0.
  2. `mem_stall`: all `*_ex` registers hold. If `flush_ex` is asserted, set `flush_pending`.
  3. `flush_ex | flush_pending`: load a bubble and clear `flush_pending`.
  4. `load_stop`: load a bubble.
  5. Otherwise capture the ID fields and `op*_next`. Set `valid_ex = valid_id`.
- Bubble: `valid_ex`, `rf_we_ex`, `mem_we_ex`, `is_load_ex`, `is_branch_ex` = 0; `rd_ex` = 0; all other fields = 0.
- A bubble never writes the register file or memory and never triggers a branch.
- If `valid_id` = 0, `rf_we_ex`, `mem_we_ex`, `is_load_ex` and `is_branch_ex` are forced to 0 on capture.
- `pc_hold = if_id_hold = mem_stall | (load_stop & ~flush_ex & ~flush_pending)`. Flush overrides a load stall, so the PC is free to redirect.
- State: the `*_ex` registers and the 1-bit `flush_pending`. Effectively a two-state machine, IDLE ↔ FLUSH_PEND:
  - IDLE → FLUSH_PEND on `mem_stall & flush_ex`.
  - FLUSH_PEND → IDLE on the first edge with `!mem_stall`, which also loads the bubble.

## Timing
- Capture latency is 1 cycle: ID values at edge N appear on `*_ex` after edge N.
- `pc_hold`/`if_id_hold` are combinational from inputs and `flush_pending`, so they are valid in the same cycle as the hazard.
- Load-use: exactly one bubble per `load_stop` cycle. The forwarding unit deasserts `load_stop` on the next cycle, once the load reaches MEM.
- Reset mid-operation: state is lost, the pipe is empty after the reset edge, and `flush_pending` is cleared.
- `flush_ex` and `load_stop` in the same cycle: bubble, holds deasserted.

## Configuration
- `ID_EX_PERF_CNT_EN`: when defined, adds two 32-bit wrapping counters (outputs `bubble_cnt`, `flush_cnt`, both 0 on reset).
  - `bubble_cnt` increments on each load-use bubble insertion (priority 4 taken).
  - `flush_cnt` increments on each flush bubble insertion (priority 3 taken).
  - Neither counter increments while `mem_stall` holds the register.
- Without the macro, the counters and their ports are absent and behaviour is otherwise identical.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with random inputs → all `*_ex` = 0, `pc_hold` = 0 (with `load_stop` = 0).
- Forward select: `rdata1_id`=0x11, `rdata1_f`=0xAA, `rd1_sel`=1, `rd2_sel`=0, `rdata2_id`=0x22 → next cycle `op1_ex`=0xAA, `op2_ex`=0x22.
- Load-use: `load_stop`=1 for one cycle with `rd_id`=5, `rf_we_id`=1 →
  - `pc_hold`=`if_id_hold`=1 that cycle;
  - next cycle `valid_ex`=0, `rf_we_ex`=0, `rd_ex`=0;
  - the following cycle captures `rd_id`=5.
- Flush over stall: `flush_ex`=1 and `load_stop`=1 together → `pc_hold`=0, bubble loaded.
- Flush during `mem_stall`:
  - `mem_stall`=1 with `flush_ex`=1 for one cycle, then `mem_stall`=1 for 2 more cycles → `*_ex` unchanged for 3 cycles;
  - on the first edge with `mem_stall`=0, a bubble is loaded and `flush_pending` returns to 0.
- With `ID_EX_PERF_CNT_EN`: 3 load-use bubbles and 2 flushes → `bubble_cnt`=3, `flush_cnt`=2.
